// File: rtl/ifu_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch memory responder:
// FSM state encoding, latency limits and the default RAM window base.
package ifu_mem_responder_pkg;

   localparam int unsigned DW      = 64;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned LAT_MIN = 1;
   localparam int unsigned LAT_MAX = 15;

   localparam logic [63:0] BASE_DEFAULT = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Legal response latency, in cycles from acceptance to the response pulse.
   function automatic bit latency_ok(input int unsigned lat);
      return (lat >= LAT_MIN) && (lat <= LAT_MAX);
   endfunction

endpackage

// File: rtl/ifu_mem_responder_sram.sv
// Instruction RAM: 2^AW x DW words, one synchronous read port and one write
// port. A same-address read and write at one edge returns the old word.
module ifu_mem_responder_sram
   import ifu_mem_responder_pkg::*;
#(
   parameter int unsigned AW = 12
) (
   input  logic          i_clk,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // The read samples the array before the write lands, giving read-before-write.
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ifu_mem_responder.sv
// Slave end of the instruction-fetch bus: decodes the fetch address against
// the RAM window and returns one doubleword after a fixed LATENCY.
module ifu_mem_responder
   import ifu_mem_responder_pkg::*;
#(
   parameter int unsigned AW      = 12,
   parameter logic [63:0] BASE    = BASE_DEFAULT,
   parameter int unsigned LATENCY = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          ifu_mstReq_valid,
   input  logic [63:0]   ifu_addr,
   output logic [63:0]   ifu_data_r,
   output logic          ifu_slvRsp_valid,
   output logic          ifu_slvRsp_err,
   input  logic          flush,
   input  logic          load_valid,
   input  logic [AW-1:0] load_addr,
   input  logic [63:0]   load_data
);

   generate
      if (!latency_ok(LATENCY)) begin : g_bad_latency
         $error("ifu_mem_responder: LATENCY must be within 1..15");
      end
   endgenerate

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_accept;
   logic               w_rsp_valid_nxt;
   logic               w_rsp_err_nxt;
   logic               r_cap_err;
   logic               r_rsp_valid;
   logic               r_rsp_err;

   logic [63:0]        w_offset;
   logic [63:0]        w_word;
   logic               w_out_of_range;
   logic [AW-1:0]      w_idx;
   logic [DW-1:0]      w_ram_q;

   // Address decode: doubleword index within the window, byte bits dropped.
   assign w_offset       = ifu_addr - BASE;
   assign w_word         = w_offset >> 3;
   assign w_out_of_range = (ifu_addr < BASE) || (w_word[63:AW] != '0);
   assign w_idx          = w_word[AW-1:0];

   ifu_mem_responder_sram #(
      .AW (AW)
   ) u_sram (
      .i_clk   (CLK),
      .i_re    (w_accept),
      .i_raddr (w_idx),
      .o_rdata (w_ram_q),
      .i_we    (load_valid),
      .i_waddr (load_addr),
      .i_wdata (load_data)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_accept        = 1'b0;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (ifu_mstReq_valid && !flush) begin
               w_accept = 1'b1;
               if (LATENCY == 1) begin
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_cnt_nxt   = CNT_W'(LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_state_nxt = ST_RESP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Flush wins over every transition, including the step into RESP.
      if (flush) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end

      if (w_state_nxt == ST_RESP) begin
         w_rsp_valid_nxt = 1'b1;
         w_rsp_err_nxt   = w_accept ? w_out_of_range : r_cap_err;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt       <= '0;
         r_cap_err   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         if (w_accept) begin
            r_cap_err <= w_out_of_range;
         end
      end
   end

   // RAM output register holds the word read at acceptance; gate it to the pulse.
   assign ifu_slvRsp_valid = r_rsp_valid;
   assign ifu_slvRsp_err   = r_rsp_err;
   assign ifu_data_r       = (r_rsp_valid && !r_rsp_err) ? w_ram_q : '0;

endmodule

// File: tb/tb_ifu_mem_responder.sv
// Bench for ifu_mem_responder: three instances (LATENCY 1, 2, 3) share one
// stimulus stream and are each compared against a timeline reference model.
module tb_ifu_mem_responder;

   localparam int unsigned AW   = 6;
   localparam int unsigned NW   = 1 << AW;
   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam int          NI   = 3;

   logic          clk;
   logic          rst;
   logic          req;
   logic          flush;
   logic          lv;
   logic [63:0]   addr;
   logic [63:0]   ld;
   logic [AW-1:0] la;

   logic [63:0]   d_data  [NI];
   logic          d_valid [NI];
   logic          d_err   [NI];

   ifu_mem_responder #(.AW(AW), .BASE(BASE), .LATENCY(1)) u_lat1 (
      .CLK(clk), .RST(rst), .ifu_mstReq_valid(req), .ifu_addr(addr),
      .ifu_data_r(d_data[0]), .ifu_slvRsp_valid(d_valid[0]), .ifu_slvRsp_err(d_err[0]),
      .flush(flush), .load_valid(lv), .load_addr(la), .load_data(ld));

   ifu_mem_responder #(.AW(AW), .BASE(BASE), .LATENCY(2)) u_lat2 (
      .CLK(clk), .RST(rst), .ifu_mstReq_valid(req), .ifu_addr(addr),
      .ifu_data_r(d_data[1]), .ifu_slvRsp_valid(d_valid[1]), .ifu_slvRsp_err(d_err[1]),
      .flush(flush), .load_valid(lv), .load_addr(la), .load_data(ld));

   ifu_mem_responder #(.AW(AW), .BASE(BASE), .LATENCY(3)) u_lat3 (
      .CLK(clk), .RST(rst), .ifu_mstReq_valid(req), .ifu_addr(addr),
      .ifu_data_r(d_data[2]), .ifu_slvRsp_valid(d_valid[2]), .ifu_slvRsp_err(d_err[2]),
      .flush(flush), .load_valid(lv), .load_addr(la), .load_data(ld));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: RAM image plus, per instance, the edge at which the
   // pending response fires and the first edge a new request may be taken.
   logic [63:0] mem [NW];
   int          n;
   bit          m_pend  [NI];
   int          m_resp  [NI];
   int          m_free  [NI];
   logic [63:0] m_cdata [NI];
   bit          m_cerr  [NI];
   bit          e_valid [NI];
   logic [63:0] e_data  [NI];
   bit          e_err   [NI];
   bit          e_zero  [NI];

   int total;
   int bad;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit addr_err(input logic [63:0] a);
      logic [63:0] off;
      off = a - BASE;
      return (a < BASE) || (off >= 64'(NW * 8));
   endfunction

   // Advance the model across the coming clock edge using the current inputs.
   task automatic model_edge();
      logic [63:0]   off;
      logic [AW-1:0] idx;
      logic [63:0]   rd;
      bit            oor;
      int            lat;
      oor = addr_err(addr);
      off = addr - BASE;
      idx = off[AW+2:3];
      rd  = oor ? 64'h0 : mem[idx];
      for (int k = 0; k < NI; k++) begin
         lat        = k + 1;
         e_valid[k] = 1'b0;
         e_zero[k]  = 1'b0;
         if (rst) begin
            m_pend[k] = 1'b0;
            m_free[k] = n + 1;
            e_zero[k] = 1'b1;
            e_data[k] = 64'h0;
            e_err[k]  = 1'b0;
         end else if (flush) begin
            m_pend[k] = 1'b0;
            m_free[k] = n + 1;
         end else if (m_pend[k]) begin
            if (n == m_resp[k]) begin
               e_valid[k] = 1'b1;
               e_data[k]  = m_cdata[k];
               e_err[k]   = m_cerr[k];
               m_pend[k]  = 1'b0;
               m_free[k]  = n + 2;
            end
         end else if (req && n >= m_free[k]) begin
            m_cdata[k] = rd;
            m_cerr[k]  = oor;
            if (lat == 1) begin
               e_valid[k] = 1'b1;
               e_data[k]  = rd;
               e_err[k]   = oor;
               m_free[k]  = n + 2;
            end else begin
               m_pend[k]  = 1'b1;
               m_resp[k]  = n + lat - 1;
            end
         end
      end
      if (lv) mem[la] = ld;
      n++;
   endtask

   task automatic compare_all();
      for (int k = 0; k < NI; k++) begin
         check($sformatf("L%0d_valid", k + 1), 64'(d_valid[k]), 64'(e_valid[k]));
         if (e_valid[k] || e_zero[k]) begin
            check($sformatf("L%0d_data", k + 1), d_data[k], e_data[k]);
            check($sformatf("L%0d_err", k + 1), 64'(d_err[k]), 64'(e_err[k]));
         end
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int c);
      req   = 1'b0;
      flush = 1'b0;
      lv    = 1'b0;
      repeat (c) cycle();
   endtask

   // Run cycles until the given instance pulses; cnt is the number of cycles taken.
   task automatic wait_rsp(input int lane, output int cnt);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         cnt++;
         if (d_valid[lane] === 1'b1) break;
      end
      if (d_valid[lane] !== 1'b1) check("rsp_timeout", 64'(0), 64'(1));
   endtask

   function automatic logic [63:0] rand_addr();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      return BASE + 64'($urandom_range(0, NW * 8 - 1));
      else if (sel == 7) return BASE - 64'($urandom_range(1, 64));
      else if (sel == 8) return BASE + 64'(NW * 8) + 64'($urandom_range(0, 64));
      else               return {$urandom, $urandom};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1);
   end

   initial begin
      int c;
      total = 0;
      bad   = 0;
      n     = 0;
      for (int k = 0; k < NI; k++) begin
         m_pend[k] = 1'b0;
         m_free[k] = 0;
         m_resp[k] = 0;
      end
      rst = 1'b1; req = 1'b0; flush = 1'b0; lv = 1'b0;
      addr = BASE; la = '0; ld = '0;
      cycle();
      cycle();
      rst = 1'b0;

      // Preload: RAM[i] = i+1, with a marker word at index 5.
      for (int i = 0; i < int'(NW); i++) begin
         lv = 1'b1;
         la = AW'(i);
         ld = (i == 5) ? 64'hDEAD_BEEF_0000_0013 : 64'(i + 1);
         cycle();
      end
      idle(4);

      // Aligned and unaligned fetch of the same word, back to back.
      addr = BASE + 64'h28; req = 1'b1;
      wait_rsp(1, c);
      check("w5_lat", 64'(c), 64'(2));
      check("w5_data", d_data[1], 64'hDEAD_BEEF_0000_0013);
      check("w5_err", 64'(d_err[1]), 64'(0));
      addr = BASE + 64'h2C;
      wait_rsp(1, c);
      check("w5u_gap", 64'(c), 64'(3));
      check("w5u_data", d_data[1], 64'hDEAD_BEEF_0000_0013);
      idle(4);

      // Sequential fetches with valid held high throughout.
      req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         addr = BASE + 64'(8 * i);
         wait_rsp(1, c);
         check("seq_gap", 64'(c), (i == 0) ? 64'(2) : 64'(3));
         check("seq_data", d_data[1], 64'(i + 1));
      end
      idle(4);

      // Window boundaries: just below, just past the end, then in range.
      req = 1'b1;
      addr = BASE - 64'h8;
      wait_rsp(1, c);
      check("below_err", 64'(d_err[1]), 64'(1));
      check("below_data", d_data[1], 64'h0);
      addr = BASE + 64'(NW * 8);
      wait_rsp(1, c);
      check("above_err", 64'(d_err[1]), 64'(1));
      check("above_data", d_data[1], 64'h0);
      addr = BASE + 64'h18;
      wait_rsp(1, c);
      check("inrange_err", 64'(d_err[1]), 64'(0));
      check("inrange_data", d_data[1], 64'h4);
      idle(4);

      // Flush one cycle after acceptance drops the LATENCY=3 response.
      addr = BASE + 64'h30; req = 1'b1;
      cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0; req = 1'b0;
      cycle();
      check("flush_drop", 64'(d_valid[2]), 64'(0));
      addr = BASE + 64'h38; req = 1'b1;
      wait_rsp(2, c);
      check("flush_next_lat", 64'(c), 64'(3));
      check("flush_next_data", d_data[2], 64'h8);
      idle(4);

      // Backdoor write to the fetched word at the acceptance edge.
      lv = 1'b1; la = AW'(10); ld = 64'h11;
      cycle();
      ld = 64'h22; addr = BASE + 64'h50; req = 1'b1;
      cycle();
      lv = 1'b0;
      wait_rsp(1, c);
      check("rbw_lat", 64'(c), 64'(1));
      check("rbw_old", d_data[1], 64'h11);
      wait_rsp(1, c);
      check("rbw_new", d_data[1], 64'h22);
      idle(4);

      // Asynchronous reset pulse between edges while requests are in flight.
      addr = BASE + 64'h20; req = 1'b1;
      cycle();
      req = 1'b0;
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("arst_L%0d_valid", k + 1), 64'(d_valid[k]), 64'(0));
         check($sformatf("arst_L%0d_err", k + 1), 64'(d_err[k]), 64'(0));
         check($sformatf("arst_L%0d_data", k + 1), d_data[k], 64'h0);
         m_pend[k] = 1'b0;
         m_free[k] = n;
      end
      #1 rst = 1'b0;
      idle(3);
      addr = BASE + 64'h20; req = 1'b1;
      wait_rsp(1, c);
      check("arst_fresh_lat", 64'(c), 64'(2));
      check("arst_fresh_data", d_data[1], 64'h5);
      idle(4);

      // Randomized traffic: requests, flushes, backdoor writes and resets.
      for (int i = 0; i < 3000; i++) begin
         req   = ($urandom_range(0, 9) < 6);
         addr  = rand_addr();
         flush = ($urandom_range(0, 19) == 0);
         lv    = ($urandom_range(0, 4) == 0);
         la    = AW'($urandom);
         ld    = {$urandom, $urandom};
         rst   = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0;
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
